// File: rtl/newhope_pkg.sv
// Shared constants, threshold helper and FSM state type for the NewHope message decoder.
package newhope_pkg;

  localparam int Q        = 12289;
  localparam int HALF_Q   = Q / 2;
  localparam int MSG_BITS = 256;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Decision threshold for k accumulated distances; integer division.
  function automatic int thresh(input int k, input int q);
    return (k * q) / 4;
  endfunction

endpackage

// File: rtl/coeff_dist_acc.sv
// Distance |c - Q/2| of each coefficient, K-term accumulation and threshold compare.
// The bit is produced combinationally in the cycle the last term arrives.
module coeff_dist_acc #(
  parameter int K       = 2,
  parameter int COEFF_W = 16,
  parameter int Q       = newhope_pkg::Q
) (
  input  logic               clk,
  input  logic [COEFF_W-1:0] coeff_i,
  input  logic               valid_i,
  input  logic               first_i,
  input  logic               last_i,
  output logic               bit_o,
  output logic               bit_valid_o
);
  import newhope_pkg::*;

  localparam int ACC_W = COEFF_W + 2;
  localparam int HALF  = Q / 2;
  localparam logic [ACC_W-1:0] THRESH = ACC_W'(thresh(K, Q));

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum;

  // Absolute distance from the midpoint; inputs >= Q use the same arithmetic.
  function automatic logic [ACC_W-1:0] dist_f(input logic [COEFF_W-1:0] c);
    logic signed [ACC_W-1:0] diff;
    diff = $signed({2'b00, c}) - $signed(ACC_W'(HALF));
    return (diff < 0) ? ACC_W'(-diff) : ACC_W'(diff);
  endfunction

  // Running sum restarts on the first term of each bit.
  always_comb begin
    sum         = (first_i ? '0 : acc_q) + dist_f(coeff_i);
    acc_d       = valid_i ? sum : acc_q;
    bit_o       = (sum < THRESH);
    bit_valid_o = valid_i & last_i;
  end

  // Accumulator register (data only, restarted by the first flag).
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

endmodule

// File: rtl/newhope_msg_decoder.sv
// NewHope message decoder: streams N = K*256 coefficients, one read per cycle,
// thresholds each group of K distances into a message bit and packs the bits
// into WORD_W-bit message RAM words (byte 0 in the top bits, LSB-first bytes).
module newhope_msg_decoder #(
  parameter int N       = 512,
  parameter int Q       = newhope_pkg::Q,
  parameter int COEFF_W = 16,
  parameter int WORD_W  = 32,
  parameter int RD_LAT  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(N)-1:0]          poly_addr,
  input  logic [COEFF_W-1:0]            poly_do,
  output logic                          msg_we,
  output logic [$clog2(256/WORD_W)-1:0] msg_addr,
  output logic [WORD_W-1:0]             msg_di
);
  import newhope_pkg::*;

  localparam int K   = N / 256;
  localparam int AW  = $clog2(N);
  localparam int KW  = (K > 1) ? $clog2(K) : 1;
  localparam int PW  = $clog2(WORD_W);
  localparam int MAW = $clog2(256 / WORD_W);

  state_e            state_q, state_d;
  logic [7:0]        i_q, i_d;
  logic [KW-1:0]     k_q, k_d;
  logic [AW-1:0]     poly_addr_q, poly_addr_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [RD_LAT-1:0] vld_pipe_q, vld_pipe_d;
  logic [RD_LAT-1:0] first_pipe_q, first_pipe_d;
  logic [RD_LAT-1:0] last_pipe_q, last_pipe_d;
  logic [7:0]        bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] word_q, word_d, word_set;
  logic              msg_we_q, msg_we_d;
  logic [MAW-1:0]    msg_addr_q, msg_addr_d;
  logic [WORD_W-1:0] msg_di_q, msg_di_d;
  logic              last_wr_q, last_wr_d;
  logic              start_accept, issue_vld, issue_last;
  logic              dec_bit, dec_bit_vld;
  logic [PW-1:0]     pos, idx;

  assign start_accept = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign issue_vld    = (state_q == ST_ISSUE);
  assign issue_last   = (k_q == KW'(K - 1));

  // FSM and read-address sequencing: address k*256 + i, k fastest.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    k_d     = k_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_accept) begin
          state_d = ST_ISSUE;
          i_d     = '0;
          k_d     = '0;
        end
      end
      ST_ISSUE: begin
        if (issue_last) begin
          k_d = '0;
          i_d = i_q + 8'd1;
          if (i_q == 8'hFF) state_d = ST_DRAIN;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_DRAIN: begin
        if (msg_we_q && last_wr_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = start_accept ? ST_ISSUE : ST_IDLE;
        i_d     = '0;
        k_d     = '0;
      end
    endcase
    poly_addr_d = (state_d == ST_ISSUE) ? AW'({k_d, i_d}) : '0;
    busy_d      = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
    done_d      = (state_d == ST_DONE);
  end

  // First/last/valid flags delayed to line up with the RAM read latency.
  always_comb begin
    vld_pipe_d      = '0;
    first_pipe_d    = '0;
    last_pipe_d     = '0;
    vld_pipe_d[0]   = issue_vld;
    first_pipe_d[0] = (k_q == '0);
    last_pipe_d[0]  = issue_last;
    for (int j = 1; j < RD_LAT; j++) begin
      vld_pipe_d[j]   = vld_pipe_q[j-1];
      first_pipe_d[j] = first_pipe_q[j-1];
      last_pipe_d[j]  = last_pipe_q[j-1];
    end
  end

  coeff_dist_acc #(
    .K       (K),
    .COEFF_W (COEFF_W),
    .Q       (Q)
  ) u_dist_acc (
    .clk         (clk),
    .coeff_i     (poly_do),
    .valid_i     (vld_pipe_q[RD_LAT-1]),
    .first_i     (first_pipe_q[RD_LAT-1]),
    .last_i      (last_pipe_q[RD_LAT-1]),
    .bit_o       (dec_bit),
    .bit_valid_o (dec_bit_vld)
  );

  // Bit packer: byte b sits at the top-down byte slot b, bits LSB-first.
  always_comb begin
    pos        = bit_cnt_q[PW-1:0];
    idx        = PW'(WORD_W - 8 - 8 * int'(pos >> 3) + int'(pos[2:0]));
    word_set   = word_q;
    word_set[idx] = dec_bit;
    word_d     = word_q;
    bit_cnt_d  = bit_cnt_q;
    msg_we_d   = 1'b0;
    msg_addr_d = msg_addr_q;
    msg_di_d   = msg_di_q;
    last_wr_d  = last_wr_q;
    if (start_accept) begin
      bit_cnt_d = '0;
      word_d    = '0;
    end else if (dec_bit_vld) begin
      bit_cnt_d = bit_cnt_q + 8'd1;
      if (&pos) begin
        msg_we_d   = 1'b1;
        msg_addr_d = bit_cnt_q[7:PW];
        msg_di_d   = word_set;
        word_d     = '0;
        last_wr_d  = (bit_cnt_q == 8'hFF);
      end else begin
        word_d = word_set;
      end
    end
  end

  // State registers; reset discards any run in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      i_q          <= '0;
      k_q          <= '0;
      poly_addr_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      vld_pipe_q   <= '0;
      first_pipe_q <= '0;
      last_pipe_q  <= '0;
      bit_cnt_q    <= '0;
      word_q       <= '0;
      msg_we_q     <= 1'b0;
      msg_addr_q   <= '0;
      msg_di_q     <= '0;
      last_wr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      k_q          <= k_d;
      poly_addr_q  <= poly_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      vld_pipe_q   <= vld_pipe_d;
      first_pipe_q <= first_pipe_d;
      last_pipe_q  <= last_pipe_d;
      bit_cnt_q    <= bit_cnt_d;
      word_q       <= word_d;
      msg_we_q     <= msg_we_d;
      msg_addr_q   <= msg_addr_d;
      msg_di_q     <= msg_di_d;
      last_wr_q    <= last_wr_d;
    end
  end

  assign poly_addr = poly_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign msg_we    = msg_we_q;
  assign msg_addr  = msg_addr_q;
  assign msg_di    = msg_di_q;

endmodule

// File: tb/tb_newhope_msg_decoder.sv
// Bench for newhope_msg_decoder: instance A is N=512/RD_LAT=1, instance B is
// N=1024/RD_LAT=2. Expected writes and done cycles are queued at start and
// popped by per-instance monitors sampling on the falling edge.
module tb_newhope_msg_decoder;

  typedef struct {
    int          cyc;
    int          addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_a, start_b;
  logic        busy_a, done_a, msg_we_a, busy_b, done_b, msg_we_b;
  logic [8:0]  poly_addr_a;
  logic [9:0]  poly_addr_b;
  logic [15:0] poly_do_a, poly_do_b;
  logic [2:0]  msg_addr_a, msg_addr_b;
  logic [31:0] msg_di_a, msg_di_b;

  logic [15:0] mem_a [0:1023];
  logic [15:0] mem_b [0:1023];
  logic [15:0] ra, rb1, rb2;
  logic [31:0] exp_words_a [0:7];
  logic [31:0] exp_words_b [0:7];

  wr_t sb_a[$], sb_b[$];
  int  dq_a[$], dq_b[$];
  wr_t e_a, e_b;
  int  ed_a, ed_b;
  int  cyc = 0;
  int  run_s_a = -1, run_s_b = -1;
  int  done_cnt_a = 0, done_cnt_b = 0;
  int  n_checks = 0, n_pass = 0;

  newhope_msg_decoder #(.N(512), .Q(12289), .COEFF_W(16), .WORD_W(32), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .poly_addr(poly_addr_a), .poly_do(poly_do_a), .msg_we(msg_we_a),
    .msg_addr(msg_addr_a), .msg_di(msg_di_a)
  );

  newhope_msg_decoder #(.N(1024), .Q(12289), .COEFF_W(16), .WORD_W(32), .RD_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .poly_addr(poly_addr_b), .poly_do(poly_do_b), .msg_we(msg_we_b),
    .msg_addr(msg_addr_b), .msg_di(msg_di_b)
  );

  // Poly RAM models: latency 1 for A, latency 2 for B.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    ra  <= mem_a[{1'b0, poly_addr_a}];
    rb1 <= mem_b[poly_addr_b];
    rb2 <= rb1;
  end
  assign poly_do_a = ra;
  assign poly_do_b = rb2;

  // Reference message word from the coefficient memory.
  function automatic logic [31:0] exp_word(input logic [15:0] m [0:1023], input int k, input int w);
    logic [31:0] r;
    int sum, c, d;
    r = '0;
    for (int p = 0; p < 32; p++) begin
      sum = 0;
      for (int kk = 0; kk < k; kk++) begin
        c = int'(m[kk * 256 + w * 32 + p]);
        d = (c >= 6144) ? c - 6144 : 6144 - c;
        sum += d;
      end
      if (sum < (k * 12289) / 4) r[24 - 8 * (p / 8) + (p % 8)] = 1'b1;
    end
    return r;
  endfunction

  // Monitor A: scoreboard writes, done timing, address sequence.
  always @(negedge clk) begin
    if (msg_we_a) begin
      n_checks++;
      if (sb_a.size() == 0) begin
        $display("FAIL wr_a_unexpected: got write addr=%0d data=%h at cyc %0d, required no write", msg_addr_a, msg_di_a, cyc);
      end else begin
        e_a = sb_a.pop_front();
        if (msg_addr_a !== 3'(e_a.addr) || msg_di_a !== e_a.data || cyc !== e_a.cyc)
          $display("FAIL wr_a: got addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                   msg_addr_a, msg_di_a, cyc, e_a.addr, e_a.data, e_a.cyc);
        else n_pass++;
      end
    end
    if (done_a) begin
      done_cnt_a++;
      n_checks++;
      if (dq_a.size() == 0) begin
        $display("FAIL done_a_unexpected: got done at cyc %0d, required none", cyc);
      end else begin
        ed_a = dq_a.pop_front();
        if (cyc !== ed_a || busy_a !== 1'b0)
          $display("FAIL done_a: got cyc=%0d busy=%b, required cyc=%0d busy=0", cyc, busy_a, ed_a);
        else n_pass++;
      end
    end
    if (run_s_a >= 0 && cyc - run_s_a >= 1 && cyc - run_s_a <= 512) begin
      n_checks++;
      if (poly_addr_a !== 9'(((cyc - run_s_a - 1) % 2) * 256 + (cyc - run_s_a - 1) / 2) || busy_a !== 1'b1)
        $display("FAIL addr_a: got addr=%0d busy=%b at rel %0d, required addr=%0d busy=1", poly_addr_a, busy_a,
                 cyc - run_s_a, ((cyc - run_s_a - 1) % 2) * 256 + (cyc - run_s_a - 1) / 2);
      else n_pass++;
    end
  end

  // Monitor B: same checks for the K=4 instance.
  always @(negedge clk) begin
    if (msg_we_b) begin
      n_checks++;
      if (sb_b.size() == 0) begin
        $display("FAIL wr_b_unexpected: got write addr=%0d data=%h at cyc %0d, required no write", msg_addr_b, msg_di_b, cyc);
      end else begin
        e_b = sb_b.pop_front();
        if (msg_addr_b !== 3'(e_b.addr) || msg_di_b !== e_b.data || cyc !== e_b.cyc)
          $display("FAIL wr_b: got addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                   msg_addr_b, msg_di_b, cyc, e_b.addr, e_b.data, e_b.cyc);
        else n_pass++;
      end
    end
    if (done_b) begin
      done_cnt_b++;
      n_checks++;
      if (dq_b.size() == 0) begin
        $display("FAIL done_b_unexpected: got done at cyc %0d, required none", cyc);
      end else begin
        ed_b = dq_b.pop_front();
        if (cyc !== ed_b || busy_b !== 1'b0)
          $display("FAIL done_b: got cyc=%0d busy=%b, required cyc=%0d busy=0", cyc, busy_b, ed_b);
        else n_pass++;
      end
    end
    if (run_s_b >= 0 && cyc - run_s_b >= 1 && cyc - run_s_b <= 1024) begin
      n_checks++;
      if (poly_addr_b !== 10'(((cyc - run_s_b - 1) % 4) * 256 + (cyc - run_s_b - 1) / 4) || busy_b !== 1'b1)
        $display("FAIL addr_b: got addr=%0d busy=%b at rel %0d, required addr=%0d busy=1", poly_addr_b, busy_b,
                 cyc - run_s_b, ((cyc - run_s_b - 1) % 4) * 256 + (cyc - run_s_b - 1) / 4);
      else n_pass++;
    end
  end

  // Called just after a falling edge: start is sampled at the next rising edge.
  task automatic start_a_run();
    wr_t e;
    start_a = 1'b1;
    run_s_a = cyc;
    for (int w = 0; w < 8; w++) begin
      e.cyc = cyc + (w + 1) * 64 + 2;
      e.addr = w;
      e.data = exp_words_a[w];
      sb_a.push_back(e);
    end
    dq_a.push_back(cyc + 515);
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic start_b_run();
    wr_t e;
    start_b = 1'b1;
    run_s_b = cyc;
    for (int w = 0; w < 8; w++) begin
      e.cyc = cyc + (w + 1) * 128 + 3;
      e.addr = w;
      e.data = exp_words_b[w];
      sb_b.push_back(e);
    end
    dq_b.push_back(cyc + 1028);
    @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic wait_idle_a(input int limit);
    int n;
    n = 0;
    while ((sb_a.size() != 0 || dq_a.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (sb_a.size() != 0 || dq_a.size() != 0) begin
      $display("FAIL timeout_a: got %0d writes and %0d done pending, required 0", sb_a.size(), dq_a.size());
      sb_a.delete();
      dq_a.delete();
    end else n_pass++;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_idle_b(input int limit);
    int n;
    n = 0;
    while ((sb_b.size() != 0 || dq_b.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (sb_b.size() != 0 || dq_b.size() != 0) begin
      $display("FAIL timeout_b: got %0d writes and %0d done pending, required 0", sb_b.size(), dq_b.size());
      sb_b.delete();
      dq_b.delete();
    end else n_pass++;
    repeat (3) @(negedge clk);
  endtask

  task automatic fill_a_random();
    for (int a = 0; a < 1024; a++)
      mem_a[a] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 12288));
    for (int w = 0; w < 8; w++) exp_words_a[w] = exp_word(mem_a, 2, w);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (busy_a !== 1'b0) $display("FAIL rst_busy: got %b, required 0", busy_a); else n_pass++;
    n_checks++; if (done_a !== 1'b0) $display("FAIL rst_done: got %b, required 0", done_a); else n_pass++;
    n_checks++; if (msg_we_a !== 1'b0) $display("FAIL rst_we: got %b, required 0", msg_we_a); else n_pass++;
    n_checks++; if (msg_addr_a !== 3'd0) $display("FAIL rst_maddr: got %0d, required 0", msg_addr_a); else n_pass++;
    n_checks++; if (msg_di_a !== 32'd0) $display("FAIL rst_di: got %h, required 0", msg_di_a); else n_pass++;
    n_checks++; if (poly_addr_a !== 9'd0) $display("FAIL rst_paddr: got %0d, required 0", poly_addr_a); else n_pass++;
    n_checks++; if ({busy_b, done_b, msg_we_b} !== 3'b000) $display("FAIL rst_b: got %b, required 000", {busy_b, done_b, msg_we_b}); else n_pass++;
  endtask

  task automatic test_all_zero();
    for (int a = 0; a < 1024; a++) mem_a[a] = 16'd0;
    for (int w = 0; w < 8; w++) exp_words_a[w] = 32'h0000_0000;
    start_a_run();
    wait_idle_a(2000);
  endtask

  task automatic test_all_half();
    int d0;
    for (int a = 0; a < 1024; a++) mem_a[a] = 16'd6144;
    for (int w = 0; w < 8; w++) exp_words_a[w] = 32'hFFFF_FFFF;
    d0 = done_cnt_a;
    start_a_run();
    wait_idle_a(2000);
    n_checks++; if (done_cnt_a - d0 !== 1) $display("FAIL half_done_count: got %0d, required 1", done_cnt_a - d0); else n_pass++;
    n_checks++; if (busy_a !== 1'b0) $display("FAIL half_busy_after: got %b, required 0", busy_a); else n_pass++;
  endtask

  task automatic test_threshold();
    for (int a = 0; a < 1024; a++) mem_a[a] = 16'd0;
    mem_a[0] = 16'd3072;
    mem_a[256] = 16'd3072;
    for (int w = 0; w < 8; w++) exp_words_a[w] = 32'h0000_0000;
    start_a_run();
    wait_idle_a(2000);
    mem_a[256] = 16'd3073;
    exp_words_a[0] = 32'h0100_0000;
    start_a_run();
    wait_idle_a(2000);
  endtask

  task automatic test_k4_lat2();
    for (int a = 0; a < 1024; a++) mem_b[a] = 16'd0;
    for (int kk = 0; kk < 4; kk++) mem_b[37 + kk * 256] = 16'd6144;
    for (int w = 0; w < 8; w++) exp_words_b[w] = 32'h0000_0000;
    exp_words_b[1] = 32'h2000_0000;
    start_b_run();
    wait_idle_b(3000);
  endtask

  task automatic test_reset_mid();
    int s;
    fill_a_random();
    s = cyc;
    start_a_run();
    while (cyc < s + 100) @(negedge clk);
    n_checks++;
    if (sb_a.size() !== 7) $display("FAIL rstmid_word0: got %0d pending writes, required 7", sb_a.size()); else n_pass++;
    rst = 1'b1;
    start_a = 1'b1;
    run_s_a = -1;
    sb_a.delete();
    dq_a.delete();
    @(negedge clk);
    rst = 1'b0;
    start_a = 1'b0;
    n_checks++;
    if ({busy_a, done_a, msg_we_a} !== 3'b000 || poly_addr_a !== 9'd0 || msg_di_a !== 32'd0)
      $display("FAIL rstmid_after: got busy=%b done=%b we=%b paddr=%0d di=%h, required all 0",
               busy_a, done_a, msg_we_a, poly_addr_a, msg_di_a);
    else n_pass++;
    repeat (600) @(negedge clk);
    start_a_run();
    wait_idle_a(2000);
  endtask

  task automatic test_back_to_back();
    int s;
    fill_a_random();
    s = cyc;
    start_a_run();
    while (cyc < s + 50) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    while (cyc < s + 515) @(negedge clk);
    n_checks++;
    if (done_a !== 1'b1) $display("FAIL b2b_done_cycle: got done=%b, required 1", done_a); else n_pass++;
    start_a_run();
    wait_idle_a(3000);
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    @(negedge clk);
    test_reset();
    test_all_zero();
    test_all_half();
    test_threshold();
    test_k4_lat2();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
